// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: the controller state encoding
// and the default operand width that the accumulator and adder also use.
package mult_pkg;

  localparam int MULT_N = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } mult_state_e;

endpackage

// File: rtl/mult_bit_counter.sv
// Counts the multiplier bits already shifted out. tc_o flags the last bit.
// N must be at least 2 so that the counter has at least one bit.
module mult_bit_counter
  import mult_pkg::*;
#(
  parameter int N     = MULT_N,
  parameter int CNT_W = $clog2(N)
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer for the shift-add multiplier: one Load, then Ad/Sh per multiplier
// bit, then a single-cycle Done. Holds no data bits itself.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N     = MULT_N,
  parameter int CNT_W = $clog2(N)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic St,
  input  logic M,
  output logic Load,
  output logic Ad,
  output logic Sh,
  output logic Busy,
  output logic Done
);

  mult_state_e state_q;
  logic        added_q;
  logic        load_q;
  logic        busy_q;
  logic        done_q;
  logic        last_bit;
  logic        ad_d;
  logic        sh_d;

  // Ad leaves bit 0 untouched, so added_q stops the same bit being added twice.
  assign ad_d = (state_q == RUN) && M && !added_q;
  assign sh_d = (state_q == RUN) && !ad_d;

  mult_bit_counter #(
    .N    (N),
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk_i (Clk),
    .srst_i(Reset),
    .clr_i (state_q == LOAD),
    .inc_i (sh_d && !last_bit),
    .tc_o  (last_bit)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      added_q <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (St) begin
            state_q <= LOAD;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= RUN;
          load_q  <= 1'b0;
          added_q <= 1'b0;
        end
        RUN: begin
          added_q <= ad_d;
          if (sh_d && last_bit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Load = load_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Ad   = ad_d;
  assign Sh   = sh_d;

endmodule
